// File: rtl/wb_mem_arbiter_pkg.sv
// Shared state encodings, Wishbone CTI/BTE codes and the round-robin pick
// used by the two-master memory arbiter.
package wb_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_e;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  // Grant decision from IDLE; last_m1 is 1 when m1 held the most recent grant.
  function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                          input logic last_m1);
    if (req0 && req1) return last_m1 ? ARB_GNT0 : ARB_GNT1;
    else if (req0)    return ARB_GNT0;
    else if (req1)    return ARB_GNT1;
    else              return ARB_IDLE;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter: counts unanswered strobe cycles and emits a
// one-cycle timeout pulse. Only compiled when ARB_WATCHDOG_EN is defined.
`ifdef ARB_WATCHDOG_EN
module wb_arb_watchdog
  import wb_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic granted_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic state_chg_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    count_d   = count_q;
    timeout_d = 1'b0;
    if (!granted_i || !stb_i || ack_i || err_i || state_chg_i) begin
      count_d = '0;
    end else if (count_q == CNT_LAST) begin
      count_d   = '0;
      timeout_d = 1'b1;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule
`endif

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the shared RAM port.
// Define ARB_WATCHDOG_EN to terminate transactions the slave never answers.
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [29:0] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [29:0] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [29:0] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       wd_timeout;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        state_d = arb_pick(m0_cyc_i, m1_cyc_i, last_q);
        if (state_d == ARB_GNT0)      last_d = 1'b0;
        else if (state_d == ARB_GNT1) last_d = 1'b1;
      end
      ARB_GNT0: if (!m0_cyc_i) state_d = ARB_IDLE;
      ARB_GNT1: if (!m1_cyc_i) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic wd_granted, wd_state_chg;
  assign wd_granted   = (state_q != ARB_IDLE);
  assign wd_state_chg = (state_d != state_q);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .granted_i  (wd_granted),
    .stb_i      (s_stb_o),
    .ack_i      (s_ack_i),
    .err_i      (s_err_i),
    .state_chg_i(wd_state_chg),
    .timeout_o  (wd_timeout)
  );
`else
  assign wd_timeout = 1'b0;
`endif

  // The timeout cycle drops cyc/stb toward the slave and turns into an err
  // for the owner; the grant itself is only released when the owner drops cyc.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    s_sel_o   = '0;
    s_data_o  = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state_q)
      ARB_GNT0: begin
        s_cyc_o   = m0_cyc_i & ~wd_timeout;
        s_stb_o   = m0_stb_i & ~wd_timeout;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_cti_o   = m0_cti_i;
        s_bte_o   = m0_bte_i;
        s_sel_o   = m0_sel_i;
        s_data_o  = m0_data_i;
        m0_data_o = s_data_i;
        m0_ack_o  = s_ack_i & ~wd_timeout;
        m0_err_o  = s_err_i | wd_timeout;
      end
      ARB_GNT1: begin
        s_cyc_o   = m1_cyc_i & ~wd_timeout;
        s_stb_o   = m1_stb_i & ~wd_timeout;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_cti_o   = m1_cti_i;
        s_bte_o   = m1_bte_i;
        s_sel_o   = m1_sel_i;
        s_data_o  = m1_data_i;
        m1_data_o = s_data_i;
        m1_ack_o  = s_ack_i & ~wd_timeout;
        m1_err_o  = s_err_i | wd_timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter: grant timing, routing, bursts, reset
// and the stall behaviour (with or without ARB_WATCHDOG_EN).
module tb_wb_mem_arbiter;
  import wb_mem_arbiter_pkg::*;

  typedef struct packed {
    logic        mst;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [29:0] m0_addr_i;
  logic [2:0]  m0_cti_i;
  logic [1:0]  m0_bte_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [29:0] m1_addr_i;
  logic [2:0]  m1_cti_i;
  logic [1:0]  m1_bte_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [29:0] s_addr_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_o;
  logic [31:0] s_data_i;
  logic        s_ack_i, s_err_i;

  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t exp_q[$];

  wb_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_sel_o(s_sel_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL sim_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic cycle_step();
    @(posedge clk);
    #1;
  endtask

  function automatic rsp_t mk_rsp(input logic mst, input logic err, input logic [31:0] data);
    rsp_t r;
    r.mst  = mst;
    r.err  = err;
    r.data = data;
    return r;
  endfunction

  task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                          input logic [29:0] addr, input logic [2:0] cti,
                          input logic [1:0] bte, input logic [3:0] sel,
                          input logic [31:0] data);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_addr_i = addr;
    m0_cti_i = cti; m0_bte_i = bte; m0_sel_i = sel; m0_data_i = data;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                          input logic [29:0] addr, input logic [2:0] cti,
                          input logic [1:0] bte, input logic [3:0] sel,
                          input logic [31:0] data);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_addr_i = addr;
    m1_cti_i = cti; m1_bte_i = bte; m1_sel_i = sel; m1_data_i = data;
  endtask

  task automatic slave_drive(input logic ack, input logic err, input logic [31:0] data);
    s_ack_i = ack; s_err_i = err; s_data_i = data;
  endtask

  // Observes whichever master is being answered this cycle (no comparison here).
  task automatic sample_rsp(output bit got, output rsp_t obs);
    got      = m0_ack_o | m0_err_o | m1_ack_o | m1_err_o;
    obs.mst  = m1_ack_o | m1_err_o;
    obs.err  = obs.mst ? m1_err_o : m0_err_o;
    obs.data = obs.mst ? m1_data_o : m0_data_o;
    if (got) $display("txn  t=%0t m%0d %s data=%h", $time, obs.mst, obs.err ? "err" : "ack", obs.data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_m0(0, 0, 0, '0, '0, '0, '0, '0);
    drive_m1(0, 0, 0, '0, '0, '0, '0, '0);
    slave_drive(0, 0, '0);
    cycle_step();
    cycle_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    slave_drive(1, 1, 32'hFFFF_FFFF);
    drive_m0(1, 1, 1, 30'h3FFF_FFFF, 3'b111, 2'b11, 4'hF, 32'hFFFF_FFFF);
    drive_m1(1, 1, 1, 30'h3FFF_FFFF, 3'b111, 2'b11, 4'hF, 32'hFFFF_FFFF);
    cycle_step();
    cycle_step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o, s_data_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_slave_side: got cyc=%b stb=%b addr=%h data=%h, required all 0",
               s_cyc_o, s_stb_o, s_addr_o, s_data_o);
    end
    n_cmp++;
    if ({m0_data_o, m0_ack_o, m0_err_o, m1_data_o, m1_ack_o, m1_err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_master_side: got m0 %h/%b/%b m1 %h/%b/%b, required all 0",
               m0_data_o, m0_ack_o, m0_err_o, m1_data_o, m1_ack_o, m1_err_o);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    bit   got;
    rsp_t obs, exp_r;
    cycle_step();
    drive_m0(1, 1, 0, 30'h40, WB_CTI_CLASSIC, 2'b11, 4'hF, '0);
    @(negedge clk);
    n_cmp++;
    if (s_cyc_o !== 1'b0) begin
      n_bad++; $display("FAIL single_latency: s_cyc_o=%b in request cycle, required 0", s_cyc_o);
    end
    for (int k = 1; k <= 5; k++) begin
      cycle_step();
      if (k == 3) begin
        slave_drive(1, 0, 32'hDEAD_BEEF);
        exp_q.push_back(mk_rsp(0, 0, 32'hDEAD_BEEF));
      end else begin
        slave_drive(0, 0, '0);
      end
      if (k == 4) drive_m0(0, 0, 0, '0, '0, '0, '0, '0);
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if ({s_cyc_o, s_stb_o, s_addr_o, s_bte_o, s_sel_o} !== {1'b1, 1'b1, 30'h40, 2'b11, 4'hF}) begin
          n_bad++;
          $display("FAIL single_grant: got cyc=%b stb=%b addr=%h bte=%b sel=%h, required 1 1 00000040 11 f",
                   s_cyc_o, s_stb_o, s_addr_o, s_bte_o, s_sel_o);
        end
      end
      if (k >= 4) begin
        n_cmp++;
        if (s_cyc_o !== 1'b0) begin
          n_bad++; $display("FAIL single_release k=%0d: s_cyc_o=%b, required 0", k, s_cyc_o);
        end
      end
      n_cmp++;
      if ({m1_ack_o, m1_err_o, m1_data_o} !== '0) begin
        n_bad++;
        $display("FAIL single_m1_quiet k=%0d: m1 ack=%b err=%b data=%h, required 0", k, m1_ack_o, m1_err_o, m1_data_o);
      end
      sample_rsp(got, obs);
      if (got) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL single_rsp: unexpected response %h, required none", obs);
        end else begin
          exp_r = exp_q.pop_front();
          if (obs !== exp_r) begin
            n_bad++; $display("FAIL single_rsp: got %h, required %h", obs, exp_r);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL single_pending: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    bit          got;
    rsp_t        obs, exp_r;
    logic        exp_cyc [10];
    logic [29:0] exp_addr [10];
    exp_cyc  = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    exp_addr = '{'0, 30'h100, '0, '0, 30'h200, '0, '0, 30'h100, '0, '0};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle_step();
      case (k)
        0: begin
          drive_m0(1, 1, 0, 30'h100, WB_CTI_CLASSIC, WB_BTE_LINEAR, 4'hF, 32'h0);
          drive_m1(1, 1, 1, 30'h200, WB_CTI_CLASSIC, WB_BTE_LINEAR, 4'h3, 32'h1111_1111);
        end
        1: begin
          slave_drive(1, 0, 32'hA5A5_0000);
          exp_q.push_back(mk_rsp(0, 0, 32'hA5A5_0000));
        end
        2: begin
          slave_drive(0, 0, '0);
          drive_m0(0, 0, 0, '0, '0, '0, '0, '0);
        end
        3: drive_m0(1, 1, 0, 30'h100, WB_CTI_CLASSIC, WB_BTE_LINEAR, 4'hF, 32'h0);
        4: begin
          slave_drive(1, 0, 32'h5A5A_0001);
          exp_q.push_back(mk_rsp(1, 0, 32'h5A5A_0001));
        end
        5: begin
          slave_drive(0, 0, '0);
          drive_m1(0, 0, 0, '0, '0, '0, '0, '0);
        end
        8: drive_m0(0, 0, 0, '0, '0, '0, '0, '0);
        default: ;
      endcase
      @(negedge clk);
      n_cmp++;
      if (s_cyc_o !== exp_cyc[k] || (exp_cyc[k] && s_addr_o !== exp_addr[k])) begin
        n_bad++;
        $display("FAIL rr_grant k=%0d: got cyc=%b addr=%h, required cyc=%b addr=%h",
                 k, s_cyc_o, s_addr_o, exp_cyc[k], exp_addr[k]);
      end
      if (k == 1) begin
        n_cmp++;
        if ({m1_ack_o, m1_data_o} !== '0) begin
          n_bad++; $display("FAIL rr_m1_isolated: ack=%b data=%h, required 0 0", m1_ack_o, m1_data_o);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if ({m0_ack_o, m0_data_o, s_we_o, s_data_o, s_sel_o} !== {1'b0, 32'h0, 1'b1, 32'h1111_1111, 4'h3}) begin
          n_bad++;
          $display("FAIL rr_m1_write: m0 ack=%b data=%h, s we=%b data=%h sel=%h, required 0 0 1 11111111 3",
                   m0_ack_o, m0_data_o, s_we_o, s_data_o, s_sel_o);
        end
      end
      sample_rsp(got, obs);
      if (got) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rr_rsp k=%0d: unexpected response %h, required none", k, obs);
        end else begin
          exp_r = exp_q.pop_front();
          if (obs !== exp_r) begin
            n_bad++; $display("FAIL rr_rsp k=%0d: got %h, required %h", k, obs, exp_r);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL rr_pending: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_burst();
    bit   got;
    rsp_t obs, exp_r;
    int   beats = 0;
    logic [2:0] cti_b;
    for (int k = 0; k < 9; k++) begin
      cycle_step();
      if (k <= 4) begin
        cti_b = (k >= 4) ? WB_CTI_EOB : WB_CTI_INCR;
        if (k == 0) drive_m1(1, 1, 1, 30'h400, WB_CTI_INCR, WB_BTE_LINEAR, 4'hF, 32'hB000_0000);
        else        drive_m1(1, 1, 1, 30'h400 + 30'(k - 1), (k == 4) ? WB_CTI_EOB : WB_CTI_INCR,
                             WB_BTE_LINEAR, 4'hF, 32'hB000_0000 + 32'(k - 1));
      end
      if (k == 1) drive_m0(1, 1, 0, 30'h55, WB_CTI_CLASSIC, WB_BTE_LINEAR, 4'hF, '0);
      if (k >= 1 && k <= 4) begin
        slave_drive(1, 0, 32'hC0DE_0000 + 32'(k));
        exp_q.push_back(mk_rsp(1, 0, 32'hC0DE_0000 + 32'(k)));
      end else begin
        slave_drive(0, 0, '0);
      end
      if (k == 5) drive_m1(0, 0, 0, '0, '0, '0, '0, '0);
      if (k == 8) drive_m0(0, 0, 0, '0, '0, '0, '0, '0);
      @(negedge clk);
      if (s_cyc_o && s_stb_o && s_ack_i) beats++;
      if (k >= 1 && k <= 4) begin
        cti_b = (k == 4) ? WB_CTI_EOB : WB_CTI_INCR;
        n_cmp++;
        if ({s_cyc_o, s_we_o, s_addr_o, s_cti_o, s_bte_o, s_data_o} !==
            {1'b1, 1'b1, 30'h400 + 30'(k - 1), cti_b, WB_BTE_LINEAR, 32'hB000_0000 + 32'(k - 1)}) begin
          n_bad++;
          $display("FAIL burst_beat%0d: got cyc=%b addr=%h cti=%b bte=%b data=%h, required 1 %h %b 00 %h",
                   k - 1, s_cyc_o, s_addr_o, s_cti_o, s_bte_o, s_data_o,
                   30'h400 + 30'(k - 1), cti_b, 32'hB000_0000 + 32'(k - 1));
        end
      end
      if (k == 5 || k == 6) begin
        n_cmp++;
        if (s_cyc_o !== 1'b0) begin
          n_bad++; $display("FAIL burst_handover k=%0d: s_cyc_o=%b, required 0", k, s_cyc_o);
        end
      end
      if (k == 7) begin
        n_cmp++;
        if ({s_cyc_o, s_addr_o} !== {1'b1, 30'h55}) begin
          n_bad++; $display("FAIL burst_m0_after: cyc=%b addr=%h, required 1 00000055", s_cyc_o, s_addr_o);
        end
      end
      sample_rsp(got, obs);
      if (got) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL burst_rsp k=%0d: unexpected response %h, required none", k, obs);
        end else begin
          exp_r = exp_q.pop_front();
          if (obs !== exp_r) begin
            n_bad++; $display("FAIL burst_rsp k=%0d: got %h, required %h", k, obs, exp_r);
          end
        end
      end
    end
    n_cmp++;
    if (beats != 4 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL burst_count: %0d beats, %0d outstanding, required 4 beats, 0 outstanding",
                        beats, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) begin
      cycle_step();
      case (k)
        0: drive_m1(1, 1, 1, 30'h300, WB_CTI_CLASSIC, WB_BTE_LINEAR, 4'h3, 32'hFEED_F00D);
        1: rst = 1'b1;
        2: begin
          rst = 1'b0;
          drive_m0(1, 1, 0, 30'h44, WB_CTI_CLASSIC, WB_BTE_LINEAR, 4'hF, '0);
        end
        3: drive_m1(0, 0, 0, '0, '0, '0, '0, '0);
        4: drive_m0(0, 0, 0, '0, '0, '0, '0, '0);
        default: ;
      endcase
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if ({s_cyc_o, s_we_o, s_data_o} !== {1'b1, 1'b1, 32'hFEED_F00D}) begin
          n_bad++; $display("FAIL rstmid_granted: cyc=%b we=%b data=%h, required 1 1 feedf00d",
                            s_cyc_o, s_we_o, s_data_o);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o, s_data_o,
             m0_data_o, m0_ack_o, m0_err_o, m1_data_o, m1_ack_o, m1_err_o} !== '0) begin
          n_bad++; $display("FAIL rstmid_outputs: cyc=%b stb=%b addr=%h data=%h, required all 0",
                            s_cyc_o, s_stb_o, s_addr_o, s_data_o);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if ({s_cyc_o, s_we_o, s_addr_o} !== {1'b1, 1'b0, 30'h44}) begin
          n_bad++; $display("FAIL rstmid_regrant: cyc=%b we=%b addr=%h, required 1 0 00000044",
                            s_cyc_o, s_we_o, s_addr_o);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit   got;
    rsp_t obs, exp_r;
    cycle_step();
    slave_drive(0, 0, '0);
    drive_m0(1, 1, 0, 30'h80, WB_CTI_CLASSIC, WB_BTE_LINEAR, 4'hF, '0);
`ifdef ARB_WATCHDOG_EN
    exp_q.push_back(mk_rsp(0, 1, 32'h0));
    for (int k = 1; k <= 11; k++) begin
      cycle_step();
      if (k == 11) drive_m0(0, 0, 0, '0, '0, '0, '0, '0);
      @(negedge clk);
      if (k <= 10) begin
        n_cmp++;
        if (m0_err_o !== (k == 9) || s_cyc_o !== (k != 9)) begin
          n_bad++; $display("FAIL watchdog k=%0d: err=%b cyc=%b, required err=%b cyc=%b",
                            k, m0_err_o, s_cyc_o, (k == 9), (k != 9));
        end
      end
      sample_rsp(got, obs);
      if (got) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL watchdog_rsp k=%0d: unexpected response %h, required none", k, obs);
        end else begin
          exp_r = exp_q.pop_front();
          if (obs !== exp_r) begin
            n_bad++; $display("FAIL watchdog_rsp k=%0d: got %h, required %h", k, obs, exp_r);
          end
        end
      end
    end
`else
    begin
      int errs = 0;
      for (int k = 1; k <= 2000; k++) begin
        cycle_step();
        @(negedge clk);
        sample_rsp(got, obs);
        if (got) errs++;
      end
      n_cmp++;
      if (errs != 0) begin
        n_bad++; $display("FAIL nowatchdog_err: %0d responses in 2000 cycles, required 0", errs);
      end
      n_cmp++;
      if ({s_cyc_o, s_stb_o, s_addr_o} !== {1'b1, 1'b1, 30'h80}) begin
        n_bad++; $display("FAIL nowatchdog_hold: cyc=%b stb=%b addr=%h, required 1 1 00000080",
                          s_cyc_o, s_stb_o, s_addr_o);
      end
      cycle_step();
      drive_m0(0, 0, 0, '0, '0, '0, '0, '0);
      cycle_step();
    end
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL stall_pending: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_burst();
    test_reset_mid();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
